riscv_v_uop_sequencer: RTL and testbench
========================================

RISCV_V_UOP_SEQUENCER -- requirements
Module: riscv_v_uop_sequencer

Interface
REQ-001 Parameter: NUM_REGS, default 32, vector register count; addresses are 5 bits wide.
REQ-002 Parameter: MAX_BEATS, default 8, maximum LMUL beats per instruction.
REQ-003 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port: rst, input, 1, reset; synchronous, active-high.
REQ-005 Port: clear_pipe, input, 1, synchronous pipeline flush.
REQ-006 Port: stall, input, 1, downstream hold (riscv_stall OR riscv_v_stall).
REQ-007 Port: instr_in, input, 32, raw OP-V instruction from the scalar front end.
REQ-008 Port: instr_valid_in, input, 1, instr_in is valid.
REQ-009 Port: vtype_in, input, 9, current vtype CSR value; bits [2:0] are vlmul.
REQ-010 Port: instr_ready_out, output, 1, sequencer accepts instr_in this cycle.
REQ-011 Port: instruction_id, output, 32, micro-op driven into vector decode.
REQ-012 Port: instr_valid_id, output, 1, instruction_id holds a valid micro-op.
REQ-013 Port: uop_idx_id, output, 3, beat index of the current micro-op.
REQ-014 Port: uop_last_id, output, 1, current micro-op is the final beat.
REQ-015 Port: illegal_instr, output, 1, one-cycle pulse flagging a misaligned register group.
REQ-016 Port: busy, output, 1, a multi-beat sequence is in progress.

Function
REQ-017 Beat count from vlmul: 000 gives 1, 001 gives 2, 010 gives 4, 011 gives 8; 100, 101, 110 and 111 give 1.
REQ-018 States: IDLE and SEQ.
REQ-019 instr_ready_out = (state==IDLE) AND NOT stall; it is combinational.
REQ-020 Accept occurs when instr_valid_in AND instr_ready_out.
- On accept, instr_in and the beat count are latched.
- A later change of vtype_in does not affect an in-flight sequence.
REQ-021 All outputs are registered and update only when stall=0; when stall=1, every output and all state hold.
REQ-022 IDLE, no accept, stall=0: instr_valid_id<=0, instruction_id<=0, uop_idx_id<=0, uop_last_id<=0.
REQ-023 IDLE, accept: beat 0 is emitted next cycle (latency 1).
- If beats>1: state<=SEQ, counter<=1.
- Otherwise uop_last_id<=1 and state stays IDLE.
REQ-024 SEQ, stall=0: beat=counter is emitted, counter increments.
- When counter==beats-1: uop_last_id<=1 and state<=IDLE.
REQ-025 Beat k rewrites vd [11:7] to vd+k and vs2 [24:20] to vs2+k.
REQ-026 vs1 [19:15] is rewritten to vs1+k only when funct3 is 000, 001 or 010.
- For all other funct3, vs1 passes unchanged (immediate or scalar source).
- All other instruction bits pass unchanged.
REQ-027 funct3==111 (vset*) always uses 1 beat, regardless of vlmul.
REQ-028 Alignment rule: on accept with beats>1, if vd, vs2, or vs1 (when it is a vector operand) is not a multiple of beats:
- illegal_instr<=1 for one cycle;
- instr_valid_id<=0;
- state stays IDLE.
REQ-029 Because of REQ-028, register arithmetic never wraps past 31; address adds are 5-bit.
REQ-030 busy = (state==SEQ).
REQ-031 clear_pipe has priority over stall and accept.
- Next cycle: state=IDLE, counter=0, instr_valid_id=0, instruction_id=0, illegal_instr=0.
- An instruction presented in the same cycle is dropped.
REQ-032 illegal_instr and a valid micro-op are never asserted in the same cycle.

Reset
REQ-033 While rst=1 at a clock edge, the following take these values next cycle, irrespective of stall:
- state=IDLE, counter=0;
- instruction_id=0, instr_valid_id=0, uop_idx_id=0, uop_last_id=0;
- illegal_instr=0, busy=0.
REQ-034 Reset in the middle of a sequence abandons the remaining beats; no further beats are emitted.

Structure
REQ-035 The following belong in riscv_v_pkg:
- OP-V opcode 7'b1010111;
- funct3 constants (OPIVV to OPCFG);
- the vlmul encoding enum;
- RISCV_V_MAX_LMUL.
REQ-036 The vlmul-to-beat-count mapping is a combinational sub-module, riscv_v_lmul_beats; everything else is in one module.

Verification
REQ-037 vtype vlmul=000, accept vadd.vv vd=3 vs2=5 vs1=7 -> one beat, unchanged, uop_last_id=1, busy=0.
REQ-038 vlmul=010, vadd.vv vd=8 vs2=4 vs1=12 -> four consecutive beats (vd,vs2,vs1) = (8,4,12), (9,5,13), (10,6,14), (11,7,15); instr_ready_out=0 for beats 1-3.
REQ-039 vlmul=001, vadd.vi vd=2 vs2=6 imm=5 -> beats (2,6,imm 5) and (3,7,imm 5); imm field unchanged.
REQ-040 vlmul=011 with vd=4 -> illegal_instr pulses 1 cycle, instr_valid_id stays 0, state IDLE.
REQ-041 vlmul=010, stall=1 during beat 2 for 3 cycles -> beat 2 held 3 cycles, then beat 3 emitted; no beat skipped or duplicated.
REQ-042 clear_pipe during beat 1 of a 4-beat sequence -> next cycle instr_valid_id=0, busy=0; a new instruction is accepted the following cycle.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared constants and helpers for the RISC-V vector micro-op sequencer.
// The package provides:
//   - the OP-V major opcode;
//   - the funct3 categories (OPIVV .. OPCFG);
//   - the vlmul encoding enum;
//   - RISCV_V_MAX_LMUL;
//   - helpers that decide whether vs1 is a vector operand and that build the micro-op for beat k.
package riscv_v_pkg;

    localparam logic [6:0] OPCODE_OP_V = 7'b1010111;

    localparam logic [2:0] OPIVV = 3'b000;
    localparam logic [2:0] OPFVV = 3'b001;
    localparam logic [2:0] OPMVV = 3'b010;
    localparam logic [2:0] OPIVI = 3'b011;
    localparam logic [2:0] OPIVX = 3'b100;
    localparam logic [2:0] OPFVF = 3'b101;
    localparam logic [2:0] OPMVX = 3'b110;
    localparam logic [2:0] OPCFG = 3'b111;

    localparam int unsigned RISCV_V_MAX_LMUL = 8;

    typedef enum logic [2:0] {
        Lmul1    = 3'b000,
        Lmul2    = 3'b001,
        Lmul4    = 3'b010,
        Lmul8    = 3'b011,
        LmulRsvd = 3'b100,
        LmulF8   = 3'b101,
        LmulF4   = 3'b110,
        LmulF2   = 3'b111
    } vlmul_t;

    // vs1 names a vector register only for the .vv categories; otherwise it is an
    // immediate or a scalar register index and must not be offset.
    function automatic logic vs1_is_vector(input logic [2:0] funct3);
        return (funct3 == OPIVV) || (funct3 == OPFVV) || (funct3 == OPMVV);
    endfunction

    // Micro-op for beat k: vd, vs2 (and vector vs1) advance by k within the group.
    function automatic logic [31:0] uop_rewrite(input logic [31:0] instr, input logic [2:0] k);
        logic [31:0] r;
        r        = instr;
        r[11:7]  = instr[11:7] + {2'b00, k};
        r[24:20] = instr[24:20] + {2'b00, k};
        if (vs1_is_vector(instr[14:12])) begin
            r[19:15] = instr[19:15] + {2'b00, k};
        end
        return r;
    endfunction

endpackage

// File: rtl/riscv_v_uop_sequencer_if.sv
// Front-end / decode handshake bundle of the vector micro-op sequencer.
// slave  : the sequencer (consumes instr_*, vtype_in, stall, clear_pipe; drives micro-ops).
// master : the surrounding pipeline (drives instructions, consumes micro-ops).
interface riscv_v_uop_sequencer_if;
    logic        clear_pipe;
    logic        stall;
    logic [31:0] instr_in;
    logic        instr_valid_in;
    logic [8:0]  vtype_in;
    logic        instr_ready_out;
    logic [31:0] instruction_id;
    logic        instr_valid_id;
    logic [2:0]  uop_idx_id;
    logic        uop_last_id;
    logic        illegal_instr;
    logic        busy;

    modport slave (
        input  clear_pipe, stall, instr_in, instr_valid_in, vtype_in,
        output instr_ready_out, instruction_id, instr_valid_id, uop_idx_id, uop_last_id,
               illegal_instr, busy
    );

    modport master (
        output clear_pipe, stall, instr_in, instr_valid_in, vtype_in,
        input  instr_ready_out, instruction_id, instr_valid_id, uop_idx_id, uop_last_id,
               illegal_instr, busy
    );
endinterface

// File: rtl/riscv_v_lmul_beats.sv
// Combinational vlmul -> beat count mapping.
// Ports: vlmul (vtype[2:0]) in, beats (1, 2, 4 or 8) out.
// Fractional and reserved LMUL settings occupy a single register, hence one beat.
module riscv_v_lmul_beats
    import riscv_v_pkg::*;
(
    input  logic [2:0] vlmul,
    output logic [3:0] beats
);

    always_comb begin
        beats = 4'd1;
        case (vlmul_t'(vlmul))
            Lmul1:   beats = 4'd1;
            Lmul2:   beats = 4'd2;
            Lmul4:   beats = 4'd4;
            Lmul8:   beats = 4'd8;
            default: beats = 4'd1;
        endcase
    end

endmodule

// File: rtl/riscv_v_uop_sequencer.sv
// Splits one OP-V instruction into LMUL register-group beats for vector decode.
// Ports:
//   - clk, rst: single clock; synchronous active-high reset.
//   - bus (slave): clear_pipe, stall, instr_in/instr_valid_in/vtype_in in;
//     instr_ready_out, instruction_id, instr_valid_id, uop_idx_id, uop_last_id,
//     illegal_instr and busy out.
// All outputs except instr_ready_out and busy are registered and frozen while stall is high.
module riscv_v_uop_sequencer
    import riscv_v_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned MAX_BEATS = RISCV_V_MAX_LMUL
) (
    input  logic                    clk,
    input  logic                    rst,
    riscv_v_uop_sequencer_if.slave  bus
);

    localparam logic StIdle = 1'b0;
    localparam logic StSeq  = 1'b1;

    localparam logic [3:0] MaxBeats = 4'(MAX_BEATS);
    localparam logic [5:0] RegLimit = 6'(NUM_REGS);

    logic        state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  beats_q, beats_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_q, id_d;
    logic        valid_q, valid_d;
    logic [2:0]  idx_q, idx_d;
    logic        last_q, last_d;
    logic        ill_q, ill_d;

    logic [3:0]  lmul_beats;
    logic [3:0]  beats_new;
    logic [4:0]  grp_mask;
    logic [4:0]  vd, vs2, vs1;
    logic [2:0]  funct3;
    logic        misaligned;
    logic        accept;
    logic        unused_vtype;

    assign unused_vtype = ^bus.vtype_in[8:3];

    assign vd     = bus.instr_in[11:7];
    assign vs2    = bus.instr_in[24:20];
    assign vs1    = bus.instr_in[19:15];
    assign funct3 = bus.instr_in[14:12];

    riscv_v_lmul_beats u_lmul_beats (
        .vlmul (bus.vtype_in[2:0]),
        .beats (lmul_beats)
    );

    always_comb begin
        if (funct3 == OPCFG) begin
            beats_new = 4'd1;
        end else if (lmul_beats > MaxBeats) begin
            beats_new = MaxBeats;
        end else begin
            beats_new = lmul_beats;
        end
    end

    // Groups must be aligned to their size and fit in the register file, so the
    // 5-bit register adds in uop_rewrite can never wrap.
    assign grp_mask   = {1'b0, beats_new - 4'd1};
    assign misaligned = (|(vd & grp_mask)) || (|(vs2 & grp_mask)) ||
                        (vs1_is_vector(funct3) && (|(vs1 & grp_mask))) ||
                        (({1'b0, vd} + {2'b00, beats_new}) > RegLimit) ||
                        (({1'b0, vs2} + {2'b00, beats_new}) > RegLimit);

    assign bus.instr_ready_out = (state_q == StIdle) && !bus.stall;
    assign accept              = bus.instr_valid_in && bus.instr_ready_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        instr_d = instr_q;
        id_d    = id_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        ill_d   = ill_q;
        if (bus.clear_pipe) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            id_d    = 32'd0;
            valid_d = 1'b0;
            idx_d   = 3'd0;
            last_d  = 1'b0;
            ill_d   = 1'b0;
        end else if (!bus.stall) begin
            ill_d = 1'b0;
            if (state_q == StSeq) begin
                id_d    = uop_rewrite(instr_q, cnt_q);
                valid_d = 1'b1;
                idx_d   = cnt_q;
                last_d  = ({1'b0, cnt_q} == beats_q - 4'd1);
                if (last_d) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else if (accept && (beats_new > 4'd1) && misaligned) begin
                ill_d   = 1'b1;
                id_d    = 32'd0;
                valid_d = 1'b0;
                idx_d   = 3'd0;
                last_d  = 1'b0;
            end else if (accept) begin
                instr_d = bus.instr_in;
                beats_d = beats_new;
                id_d    = bus.instr_in;  // beat 0 carries no register offset
                valid_d = 1'b1;
                idx_d   = 3'd0;
                last_d  = (beats_new == 4'd1);
                if (beats_new > 4'd1) begin
                    state_d = StSeq;
                    cnt_d   = 3'd1;
                end
            end else begin
                id_d    = 32'd0;
                valid_d = 1'b0;
                idx_d   = 3'd0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            beats_q <= 4'd1;
            instr_q <= 32'd0;
            id_q    <= 32'd0;
            valid_q <= 1'b0;
            idx_q   <= 3'd0;
            last_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            instr_q <= instr_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.instruction_id = id_q;
    assign bus.instr_valid_id = valid_q;
    assign bus.uop_idx_id     = idx_q;
    assign bus.uop_last_id    = last_q;
    assign bus.illegal_instr  = ill_q;
    assign bus.busy           = (state_q == StSeq);

endmodule

// File: tb/tb_riscv_v_uop_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed micro-ops, a negedge monitor pops and
// compares each beat the DUT presents while stall is low.
module tb_riscv_v_uop_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    riscv_v_uop_sequencer_if dut_if ();

    riscv_v_uop_sequencer #(
        .NUM_REGS  (32),
        .MAX_BEATS (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic [31:0] instr;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] vd,
                                       input logic [4:0] vs2, input logic [4:0] vs1);
        return {6'b000000, 1'b1, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    task automatic push_beat(input logic [31:0] instr, input logic [2:0] idx, input logic last);
        exp_t e;
        e.ill = 1'b0; e.instr = instr; e.idx = idx; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_illegal();
        exp_t e;
        e = '0;
        e.ill = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        dut_if.instr_in       = instr;
        dut_if.instr_valid_in = 1'b1;
        tick();
        dut_if.instr_valid_in = 1'b0;
    endtask

    // Monitor: a beat is consumed at any edge where stall is low.
    always @(negedge clk) begin
        if (!dut_if.stall && (dut_if.instr_valid_id || dut_if.illegal_instr)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output",
                      {dut_if.illegal_instr, dut_if.instr_valid_id, dut_if.instruction_id},
                      64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.ill) begin
                    check("illegal_pulse", {dut_if.illegal_instr, dut_if.instr_valid_id}, 2'b10);
                end else begin
                    check($sformatf("beat%0d", e.idx),
                          {dut_if.illegal_instr, dut_if.instr_valid_id, dut_if.instruction_id,
                           dut_if.uop_idx_id, dut_if.uop_last_id},
                          {1'b0, 1'b1, e.instr, e.idx, e.last});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dut_if.clear_pipe     = 1'b0;
        dut_if.stall          = 1'b0;
        dut_if.instr_in       = 32'd0;
        dut_if.instr_valid_in = 1'b0;
        dut_if.vtype_in       = 9'd0;

        repeat (2) tick();
        rst = 1'b0;
        check("rst_valid", dut_if.instr_valid_id, 1'b0);
        check("rst_id",    dut_if.instruction_id, 32'd0);
        check("rst_idx",   dut_if.uop_idx_id, 3'd0);
        check("rst_last",  dut_if.uop_last_id, 1'b0);
        check("rst_ill",   dut_if.illegal_instr, 1'b0);
        check("rst_busy",  dut_if.busy, 1'b0);
        check("rst_ready", dut_if.instr_ready_out, 1'b1);

        // Single beat, LMUL=1.
        dut_if.vtype_in = 9'b000000000;
        push_beat(mk(3'b000, 5'd3, 5'd5, 5'd7), 3'd0, 1'b1);
        send(mk(3'b000, 5'd3, 5'd5, 5'd7));
        check("single_busy", dut_if.busy, 1'b0);

        // LMUL=4, vector-vector: four beats, not ready while sequencing.
        dut_if.vtype_in = 9'b000000010;
        push_beat(mk(3'b000, 5'd8,  5'd4, 5'd12), 3'd0, 1'b0);
        push_beat(mk(3'b000, 5'd9,  5'd5, 5'd13), 3'd1, 1'b0);
        push_beat(mk(3'b000, 5'd10, 5'd6, 5'd14), 3'd2, 1'b0);
        push_beat(mk(3'b000, 5'd11, 5'd7, 5'd15), 3'd3, 1'b1);
        send(mk(3'b000, 5'd8, 5'd4, 5'd12));
        for (int i = 0; i < 3; i++) begin
            check("seq_ready_low", {dut_if.instr_ready_out, dut_if.busy}, 2'b01);
            tick();
        end
        check("seq_done_busy", dut_if.busy, 1'b0);

        // LMUL=2, vector-immediate: imm field stays 5.
        dut_if.vtype_in = 9'b000000001;
        push_beat(mk(3'b011, 5'd2, 5'd6, 5'd5), 3'd0, 1'b0);
        push_beat(mk(3'b011, 5'd3, 5'd7, 5'd5), 3'd1, 1'b1);
        send(mk(3'b011, 5'd2, 5'd6, 5'd5));
        tick();
        tick();

        // LMUL=8 with vd=4: misaligned group.
        dut_if.vtype_in = 9'b000000011;
        push_illegal();
        send(mk(3'b000, 5'd4, 5'd8, 5'd16));
        check("illegal_idle", {dut_if.busy, dut_if.instr_valid_id}, 2'b00);
        tick();
        check("illegal_one_cycle", dut_if.illegal_instr, 1'b0);

        // vset* under LMUL=8 is one beat, unaligned fields are irrelevant.
        push_beat(mk(3'b111, 5'd5, 5'd3, 5'd2), 3'd0, 1'b1);
        send(mk(3'b111, 5'd5, 5'd3, 5'd2));
        check("vset_busy", dut_if.busy, 1'b0);
        tick();

        // Stall while idle blocks acceptance.
        dut_if.stall = 1'b1;
        #1;
        check("stall_ready", dut_if.instr_ready_out, 1'b0);
        dut_if.stall = 1'b0;
        #1;
        check("unstall_ready", dut_if.instr_ready_out, 1'b1);

        // LMUL=4 with a 3-cycle stall on beat 2; vtype change mid-flight is ignored.
        dut_if.vtype_in = 9'b000000010;
        push_beat(mk(3'b000, 5'd16, 5'd20, 5'd24), 3'd0, 1'b0);
        push_beat(mk(3'b000, 5'd17, 5'd21, 5'd25), 3'd1, 1'b0);
        push_beat(mk(3'b000, 5'd18, 5'd22, 5'd26), 3'd2, 1'b0);
        push_beat(mk(3'b000, 5'd19, 5'd23, 5'd27), 3'd3, 1'b1);
        send(mk(3'b000, 5'd16, 5'd20, 5'd24));
        dut_if.vtype_in = 9'b000000000;
        tick();
        tick();
        check("at_beat2", dut_if.uop_idx_id, 3'd2);
        dut_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {dut_if.instruction_id, dut_if.uop_idx_id},
                  {mk(3'b000, 5'd18, 5'd22, 5'd26), 3'd2});
        end
        dut_if.stall = 1'b0;
        tick();
        check("after_stall_idx", dut_if.uop_idx_id, 3'd3);
        tick();

        // clear_pipe on beat 1; the concurrently offered instruction is dropped.
        dut_if.vtype_in = 9'b000000010;
        push_beat(mk(3'b000, 5'd0, 5'd8, 5'd12), 3'd0, 1'b0);
        push_beat(mk(3'b000, 5'd1, 5'd9, 5'd13), 3'd1, 1'b0);
        send(mk(3'b000, 5'd0, 5'd8, 5'd12));
        tick();
        dut_if.clear_pipe     = 1'b1;
        dut_if.instr_in       = mk(3'b000, 5'd20, 5'd20, 5'd20);
        dut_if.instr_valid_in = 1'b1;
        tick();
        dut_if.clear_pipe     = 1'b0;
        dut_if.instr_valid_in = 1'b0;
        check("clear_state",
              {dut_if.instr_valid_id, dut_if.busy, dut_if.instr_ready_out, dut_if.instruction_id},
              {1'b0, 1'b0, 1'b1, 32'd0});
        dut_if.vtype_in = 9'b000000000;
        push_beat(mk(3'b000, 5'd1, 5'd2, 5'd3), 3'd0, 1'b1);
        send(mk(3'b000, 5'd1, 5'd2, 5'd3));
        tick();

        // clear_pipe while idle drops the presented instruction.
        dut_if.clear_pipe     = 1'b1;
        dut_if.instr_in       = mk(3'b000, 5'd6, 5'd6, 5'd6);
        dut_if.instr_valid_in = 1'b1;
        tick();
        dut_if.clear_pipe     = 1'b0;
        dut_if.instr_valid_in = 1'b0;
        check("clear_idle_drop", dut_if.instr_valid_id, 1'b0);
        tick();

        // Reset during beat 1 abandons beats 2 and 3.
        dut_if.vtype_in = 9'b000000010;
        push_beat(mk(3'b000, 5'd24, 5'd28, 5'd0), 3'd0, 1'b0);
        push_beat(mk(3'b000, 5'd25, 5'd29, 5'd1), 3'd1, 1'b0);
        send(mk(3'b000, 5'd24, 5'd28, 5'd0));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs",
              {dut_if.instr_valid_id, dut_if.busy, dut_if.uop_idx_id, dut_if.uop_last_id,
               dut_if.illegal_instr, dut_if.instruction_id},
              {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0});
        repeat (4) tick();
        check("midrst_quiet", {dut_if.instr_valid_id, dut_if.busy}, 2'b00);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
